// File: rtl/mmu_sched.sv
// Two-requester job scheduler in front of a 2x2 matrix-multiply array.
// Round-robin grant, single job in flight, timeout abort, held response.
module mmu_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_err,
    output logic        mmu_start,
    output logic [31:0] mmu_a,
    output logic [31:0] mmu_b,
    input  logic [31:0] mmu_c,
    input  logic        mmu_done,
    output logic        busy
);

    localparam logic [7:0] TO_C = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;
    logic        sel;

    // On contention the requester that did not finish last wins.
    assign sel = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        err_d     = err_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        mmu_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[sel] = 1'b1;
                    gnt_d   = sel;
                    opa_d   = sel ? req_a[63:32] : req_a[31:0];
                    opb_d   = sel ? req_b[63:32] : req_b[31:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mmu_start = 1'b1;
                cnt_d     = 8'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mmu_done) begin
                    res_d   = mmu_c;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_d == TO_C) begin
                    res_d   = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign mmu_a   = opa_q;
    assign mmu_b   = opb_q;
    assign rsp_c   = res_q;
    assign rsp_err = err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mmu_sched.sv
// Directed bench for mmu_sched with a behavioural 2x2 saturating array.
// Array answers 6 cycles after start unless told to hang.
module tb_mmu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_c;
    logic        rsp_err;
    logic        mmu_start;
    logic [31:0] mmu_a;
    logic [31:0] mmu_b;
    logic [31:0] mmu_c;
    logic        mmu_done;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mmu_sched #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .mmu_start (mmu_start),
        .mmu_a     (mmu_a),
        .mmu_b     (mmu_b),
        .mmu_c     (mmu_c),
        .mmu_done  (mmu_done),
        .busy      (busy)
    );

    // Array model: C[i][j] = sum_k A[i][k]*B[k][j], saturated to 8 bits.
    logic [3:0]  dcnt = 4'd0;
    logic [31:0] mc = 32'd0;
    logic        hang = 1'b0;

    function automatic logic [7:0] el(input logic [31:0] m, input int i, input int j);
        return m[(i*2+j)*8 +: 8];
    endfunction

    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        logic [16:0] s;
        c = 32'd0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 17'(el(a, i, 0) * el(b, 0, j)) + 17'(el(a, i, 1) * el(b, 1, j));
                c[(i*2+j)*8 +: 8] = (s > 17'd255) ? 8'hFF : s[7:0];
            end
        end
        return c;
    endfunction

    always @(posedge clk) begin
        if (mmu_start) begin
            dcnt <= 4'd6;
            mc   <= matmul(mmu_a, mmu_b);
        end else if (dcnt != 4'd0) begin
            dcnt <= dcnt - 4'd1;
        end
    end

    assign mmu_done = (dcnt == 4'd1) && !hang;
    assign mmu_c    = mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        err;
        logic        hang;
        logic        poke;
        int          lat;
        int          hold;
    } vec_t;

    vec_t v[5];

    task automatic run_job(input vec_t t);
        int n;
        logic [1:0] me;
        logic [1:0] other;
        logic ok;
        me    = t.r ? 2'b10 : 2'b01;
        other = ~me;
        @(posedge clk); #1;
        hang      = t.hang;
        req_valid = me;
        req_a     = {t.a, t.a} ^ (t.r ? 64'h0 : 64'hFFFF_FFFF_0000_0000);
        req_b     = {t.b, t.b} ^ (t.r ? 64'h0 : 64'hFFFF_FFFF_0000_0000);
        if (t.r) begin
            req_a[31:0] = ~t.a;
            req_b[31:0] = ~t.b;
        end
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("req_ready accept", {30'd0, req_ready}, {30'd0, me});
        n = 0;
        do begin
            @(posedge clk); #1;
            req_valid = (t.poke && n >= 1 && n <= 3) ? other : 2'b00;
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("mmu_start pulse", {31'd0, mmu_start}, 32'd1);
                chk("mmu_a", mmu_a, t.a);
                chk("mmu_b", mmu_b, t.b);
            end
            if (n == 2) chk("mmu_start low", {31'd0, mmu_start}, 32'd0);
            if (n == 3) chk("req_ready busy", {30'd0, req_ready}, 32'd0);
        end while (rsp_valid == 2'b00 && n < 400);
        chk("latency", n, t.lat);
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, me});
        chk("rsp_c", rsp_c, t.c);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, t.err});
        ok = 1'b1;
        for (int k = 0; k < t.hold; k++) begin
            @(posedge clk); #1;
            req_valid = other;
            rsp_ready = other;
            @(negedge clk);
            if (rsp_valid != me || rsp_c != t.c || rsp_err != t.err ||
                req_ready != 2'b00 || busy != 1'b1) ok = 1'b0;
        end
        if (t.hold > 0) chk("backpressure hold", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = me;
        @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("busy after resp", {31'd0, busy}, 32'd0);
        chk("rsp_valid after", {30'd0, rsp_valid}, 32'd0);
        if (t.poke) begin
            ok = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (req_ready != 2'b00 || busy != 1'b0) ok = 1'b0;
            end
            chk("no queued grant", {31'd0, ok}, 32'd1);
        end
        hang = 1'b0;
    endtask

    initial begin
        int n;
        int ng;
        int nr;
        logic [1:0] gl[4];
        logic ok;

        v[0] = '{1'b0, 32'h04030201, 32'h08070605, 32'h322B1613, 1'b0, 1'b0, 1'b0, 8, 10};
        v[1] = '{1'b1, 32'h10101010, 32'h10101010, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 8, 0};
        v[2] = '{1'b0, 32'h01000001, 32'h0A141E28, 32'h0A141E28, 1'b0, 1'b0, 1'b1, 8, 0};
        v[3] = '{1'b1, 32'h05050505, 32'h03030303, 32'h00000000, 1'b1, 1'b1, 1'b0, 18, 0};
        v[4] = '{1'b1, 32'h03000002, 32'h60606060, 32'hFFFFC0C0, 1'b0, 1'b0, 1'b0, 8, 0};

        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = 64'd0;
        req_b     = 64'd0;
        rsp_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset rsp_c", rsp_c, 32'd0);
        chk("reset mmu_a", mmu_a, 32'd0);
        chk("reset mmu_start", {31'd0, mmu_start}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(v[i]);

        // Contention, both requesters held valid with ready held high.
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_a     = {32'h01000001, 32'h04030201};
        req_b     = {32'h0A141E28, 32'h08070605};
        rsp_ready = 2'b11;
        ng = 0;
        nr = 0;
        n  = 0;
        while (nr < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready != 2'b00 && ng < 4) begin
                gl[ng] = req_ready;
                ng++;
            end
            if (rsp_valid != 2'b00) begin
                chk("contention rsp_c", rsp_c,
                    rsp_valid[1] ? 32'h0A141E28 : 32'h322B1613);
                nr++;
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        chk("contention results", nr, 4);
        chk("grant 0", {30'd0, gl[0]}, 32'd1);
        chk("grant 1", {30'd0, gl[1]}, 32'd2);
        chk("grant 2", {30'd0, gl[2]}, 32'd1);
        chk("grant 3", {30'd0, gl[3]}, 32'd2);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("contention idle", {31'd0, busy}, 32'd0);

        // Reset while the array is working; its late done must be ignored.
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_a     = {32'h04030201, 32'h0};
        req_b     = {32'h08070605, 32'h0};
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid reset outs",
            {req_ready, rsp_valid, rsp_err, mmu_start, busy, 25'd0},
            32'd0);
        chk("mid reset mmu_a", mmu_a | mmu_b | rsp_c, 32'd0);
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || busy != 1'b0) ok = 1'b0;
        end
        chk("late done ignored", {31'd0, ok}, 32'd1);

        @(posedge clk); #1;
        req_valid = 2'b11;
        req_a     = {32'h10101010, 32'h04030201};
        req_b     = {32'h10101010, 32'h08070605};
        @(negedge clk);
        chk("post reset grant", {30'd0, req_ready}, 32'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            n++;
        end while (rsp_valid == 2'b00 && n < 400);
        chk("post reset latency", n, 8);
        chk("post reset rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("post reset rsp_c", rsp_c, 32'h322B1613);
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("post reset idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
